// File: rtl/musa_pkg.sv
// Shared definitions for the execute/writeback datapath: ALU function codes,
// default widths, buffer occupancy states and the writeback entry record.
package musa_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'b000,
        FUNC_SUB = 3'b001,
        FUNC_MUL = 3'b010,
        FUNC_DIV = 3'b011,
        FUNC_AND = 3'b100,
        FUNC_OR  = 3'b101,
        FUNC_NOT = 3'b110
    } alu_func_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_ADDR_W-1:0] waddr;
        logic                  wen;
        alu_func_e             func;
        logic                  overflow;
        logic                  equals;
        logic                  above;
        logic                  zero;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry in-order buffer with an EMPTY/ONE/FULL occupancy FSM.
// Slot 0 is always the head; the entry type is a parameter so widths follow the top.
module wb_skid_buffer
    import musa_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    input  logic   flush,
    output logic   ready,
    output logic   head_valid,
    output entry_t head,
    output logic   tail_valid,
    output entry_t tail
);

    occ_state_e state_q, state_d;
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic       accept;

    // Ready depends only on registered occupancy, never on the downstream port.
    assign ready  = !reset && (state_q != OCC_FULL);
    assign accept = push && ready;

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    slot0_d = push_entry;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                unique case ({accept, pop})
                    2'b10: begin
                        slot1_d = push_entry;
                        state_d = OCC_FULL;
                    end
                    2'b01:   state_d = OCC_EMPTY;
                    2'b11:   slot0_d = push_entry;
                    default: state_d = OCC_ONE;
                endcase
            end
            OCC_FULL: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (flush) begin
            state_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: payload slots carry no reset; the occupancy state alone says which are valid.
    always_ff @(posedge clock) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign head_valid = (state_q != OCC_EMPTY);
    assign tail_valid = (state_q == OCC_FULL);
    assign head       = slot0_q;
    assign tail       = slot1_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage: buffers ALU results, drains them to the register file,
// keeps status flags and forwards the youngest pending write. Macro: OVERFLOW_TRAP_EN.
module alu_writeback_stage
    import musa_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [2:0]        in_func,
    input  logic              in_overflow,
    input  logic              in_equals,
    input  logic              in_above,
    input  logic              in_zero,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_waddr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    input  logic              status_clr,
`ifdef OVERFLOW_TRAP_EN
    output logic              trap_req,
`endif
    output logic              st_zero,
    output logic              st_equals,
    output logic              st_above,
    output logic              st_overflow
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [ADDR_W-1:0] waddr;
        logic              wen;
        alu_func_e         func;
        logic              overflow;
        logic              equals;
        logic              above;
        logic              zero;
    } entry_t;

    entry_t in_entry, head, tail;
    logic   head_valid, tail_valid;
    logic   head_writes, tail_writes, trap_hit, retire;
    logic   st_zero_q, st_zero_d, st_equals_q, st_equals_d;
    logic   st_above_q, st_above_d, st_overflow_q, st_overflow_d;

    assign in_entry = '{result:   in_result,
                        waddr:    in_waddr,
                        wen:      in_wen,
                        func:     alu_func_e'(in_func),
                        overflow: in_overflow,
                        equals:   in_equals,
                        above:    in_above,
                        zero:     in_zero};

    wb_skid_buffer #(.entry_t(entry_t)) u_buf (
        .clock      (clock),
        .reset      (reset),
        .push       (in_valid),
        .push_entry (in_entry),
        .pop        (retire),
        .flush      (trap_hit),
        .ready      (in_ready),
        .head_valid (head_valid),
        .head       (head),
        .tail_valid (tail_valid),
        .tail       (tail)
    );

    // Writes to register 0 are dropped, so such entries retire without the port.
    always_comb begin
        head_writes = head.wen && (head.waddr != '0);
        tail_writes = tail.wen && (tail.waddr != '0);
        trap_hit    = 1'b0;
`ifdef OVERFLOW_TRAP_EN
        trap_hit    = head_valid && head.overflow;
`endif
        rf_we    = head_valid && head_writes && !trap_hit;
        rf_waddr = head_valid ? head.waddr  : '0;
        rf_wdata = head_valid ? head.result : '0;
        retire   = head_valid && (!rf_we || rf_ready);
    end

`ifdef OVERFLOW_TRAP_EN
    assign trap_req = trap_hit;
`endif

    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
        if (tail_valid && tail_writes) begin
            fwd_valid = 1'b1;
            fwd_addr  = tail.waddr;
            fwd_data  = tail.result;
        end else if (head_valid && head_writes) begin
            fwd_valid = 1'b1;
            fwd_addr  = head.waddr;
            fwd_data  = head.result;
        end
    end

    // Overflow set has priority over a simultaneous clear so no event is lost.
    always_comb begin
        st_zero_d     = st_zero_q;
        st_equals_d   = st_equals_q;
        st_above_d    = st_above_q;
        st_overflow_d = st_overflow_q;
        if (retire) begin
            st_zero_d = head.zero;
            if (head.func == FUNC_SUB) begin
                st_equals_d = head.equals;
                st_above_d  = head.above;
            end
        end
        if (retire && head.overflow) begin
            st_overflow_d = 1'b1;
        end else if (status_clr) begin
            st_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_zero_q     <= 1'b0;
            st_equals_q   <= 1'b0;
            st_above_q    <= 1'b0;
            st_overflow_q <= 1'b0;
        end else begin
            st_zero_q     <= st_zero_d;
            st_equals_q   <= st_equals_d;
            st_above_q    <= st_above_d;
            st_overflow_q <= st_overflow_d;
        end
    end

    assign st_zero     = st_zero_q;
    assign st_equals   = st_equals_q;
    assign st_above    = st_above_q;
    assign st_overflow = st_overflow_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios plus randomized traffic against
// a queue-based reference model. Honors OVERFLOW_TRAP_EN when defined.
module tb_alu_writeback_stage;

`ifdef OVERFLOW_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_func;
    logic        in_overflow, in_equals, in_above, in_zero, in_wen;
    logic [4:0]  in_waddr;
    logic        rf_we, rf_ready;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        status_clr;
    logic        st_zero, st_equals, st_above, st_overflow;
    logic        trap_req;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  waddr;
        logic        wen;
        logic [2:0]  func;
        logic        ovf, eq, ab, zr;
    } m_ent_t;

    m_ent_t mq[$];
    logic   m_zero, m_eq, m_ab, m_ovf;

    always #5 clock = ~clock;

    alu_writeback_stage dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_func     (in_func),
        .in_overflow (in_overflow),
        .in_equals   (in_equals),
        .in_above    (in_above),
        .in_zero     (in_zero),
        .in_wen      (in_wen),
        .in_waddr    (in_waddr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_ready    (rf_ready),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .status_clr  (status_clr),
`ifdef OVERFLOW_TRAP_EN
        .trap_req    (trap_req),
`endif
        .st_zero     (st_zero),
        .st_equals   (st_equals),
        .st_above    (st_above),
        .st_overflow (st_overflow)
    );

`ifndef OVERFLOW_TRAP_EN
    assign trap_req = 1'b0;
`endif

    task automatic set_op(input logic [31:0] res, input logic [2:0] fn, input logic wen,
                          input logic [4:0] wa, input logic ovf, input logic eq,
                          input logic ab, input logic zr);
        in_valid = 1'b1; in_result = res; in_func = fn; in_wen = wen; in_waddr = wa;
        in_overflow = ovf; in_equals = eq; in_above = ab; in_zero = zr;
    endtask

    task automatic idle();
        set_op(32'h0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
    endtask

    // Reference model: a FIFO of at most two pending ops that drains in order.
    task automatic advance();
        m_ent_t h;
        bit rdy, hw, trap, ret, acc;
        rdy  = !reset && (mq.size() < 2);
        acc  = in_valid && rdy;
        ret  = 1'b0;
        trap = 1'b0;
        if (reset) begin
            mq.delete();
            {m_zero, m_eq, m_ab, m_ovf} = 4'b0;
        end else begin
            if (mq.size() > 0) begin
                h    = mq[0];
                trap = TRAP_EN && h.ovf;
                hw   = h.wen && (h.waddr != 5'd0) && !trap;
                ret  = !hw || rf_ready;
            end
            if (ret) begin
                m_zero = h.zr;
                if (h.func == 3'b001) begin
                    m_eq = h.eq;
                    m_ab = h.ab;
                end
                mq.delete(0);
                if (trap) mq.delete();
            end
            if (ret && h.ovf) m_ovf = 1'b1;
            else if (status_clr) m_ovf = 1'b0;
            if (acc && !trap)
                mq.push_back('{in_result, in_waddr, in_wen, in_func,
                               in_overflow, in_equals, in_above, in_zero});
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [81:0] model_outputs();
        logic        rdy, we, fv, trp;
        logic [4:0]  wa, fa;
        logic [31:0] wd, fd;
        rdy = !reset && (mq.size() < 2);
        we = 1'b0; wa = '0; wd = '0; fv = 1'b0; fa = '0; fd = '0; trp = 1'b0;
        if (mq.size() > 0) begin
            trp = TRAP_EN && mq[0].ovf;
            we  = mq[0].wen && (mq[0].waddr != 5'd0) && !trp;
            wa  = mq[0].waddr;
            wd  = mq[0].result;
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!fv && mq[i].wen && (mq[i].waddr != 5'd0)) begin
                fv = 1'b1; fa = mq[i].waddr; fd = mq[i].result;
            end
        end
        return {rdy, we, wa, wd, fv, fa, fd, m_zero, m_eq, m_ab, m_ovf, trp};
    endfunction

    task automatic test_reset();
        reset = 1'b1; rf_ready = 1'b1; status_clr = 1'b0;
        idle();
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_pre: got %0h want 0", in_ready); end
        advance();
        advance();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0h want 0", in_ready); end
        total++; if ({rf_we, rf_waddr, rf_wdata} !== 38'h0) begin bad++; $display("FAIL rst_rf: got %0h want 0", {rf_we, rf_waddr, rf_wdata}); end
        total++; if ({fwd_valid, fwd_addr, fwd_data} !== 38'h0) begin bad++; $display("FAIL rst_fwd: got %0h want 0", {fwd_valid, fwd_addr, fwd_data}); end
        total++; if ({st_zero, st_equals, st_above, st_overflow, trap_req} !== 5'b0) begin bad++; $display("FAIL rst_status: got %0b want 00000", {st_zero, st_equals, st_above, st_overflow, trap_req}); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %0h want 1", in_ready); end
    endtask

    task automatic test_single_op();
        set_op(32'd5, 3'b000, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        idle();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'd5}) begin bad++; $display("FAIL single_rf: got we=%0h addr=%0d data=%0d want we=1 addr=3 data=5", rf_we, rf_waddr, rf_wdata); end
        total++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 5'd3, 32'd5}) begin bad++; $display("FAIL single_fwd: got v=%0h addr=%0d data=%0d want v=1 addr=3 data=5", fwd_valid, fwd_addr, fwd_data); end
        advance();
        total++; if ({rf_we, st_zero} !== 2'b00) begin bad++; $display("FAIL single_after: got we=%0h zero=%0h want 0 0", rf_we, st_zero); end
    endtask

    task automatic test_compare();
        set_op(32'd0, 3'b001, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        advance();
        idle();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL cmp_we: got %0h want 0", rf_we); end
        advance();
        total++; if ({st_equals, st_zero, st_above} !== 3'b110) begin bad++; $display("FAIL cmp_status: got eq/zero/above=%0b want 110", {st_equals, st_zero, st_above}); end
        set_op(32'd9, 3'b000, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();
        idle();
        advance();
        total++; if ({st_equals, st_zero, st_above} !== 3'b100) begin bad++; $display("FAIL cmp_hold: got eq/zero/above=%0b want 100", {st_equals, st_zero, st_above}); end
    endtask

    task automatic test_backpressure();
        int order[$];
        int acc_cycle = -1;
        rf_ready = 1'b0;
        set_op(32'd11, 3'b000, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        set_op(32'd22, 3'b000, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got %0h want 0", in_ready); end
        set_op(32'd33, 3'b000, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12 && order.size() < 3; c++) begin
            rf_ready = (c >= 1);
            #1;
            if (rf_we && rf_ready) order.push_back(int'(rf_waddr));
            if (in_valid && in_ready && acc_cycle < 0) acc_cycle = c;
            advance();
            if (acc_cycle >= 0) idle();
        end
        total++; if (acc_cycle !== 2) begin bad++; $display("FAIL bp_third_accept: got cycle %0d want 2", acc_cycle); end
        total++; if (order.size() != 3) begin bad++; $display("FAIL bp_write_count: got %0d want 3", order.size()); end
        else begin
            total++; if (order[0] != 1 || order[1] != 2 || order[2] != 3) begin bad++; $display("FAIL bp_order: got %0d,%0d,%0d want 1,2,3", order[0], order[1], order[2]); end
        end
    endtask

    task automatic test_forwarding();
        rf_ready = 1'b0;
        set_op(32'd10, 3'b000, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        set_op(32'd20, 3'b000, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        idle();
        total++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 5'd4, 32'd20}) begin bad++; $display("FAIL fwd_young: got v=%0h addr=%0d data=%0d want v=1 addr=4 data=20", fwd_valid, fwd_addr, fwd_data); end
        total++; if (rf_wdata !== 32'd10) begin bad++; $display("FAIL fwd_head_data: got %0d want 10", rf_wdata); end
        rf_ready = 1'b1;
        advance();
        advance();
        rf_ready = 1'b0;
        set_op(32'd33, 3'b000, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        set_op(32'd44, 3'b000, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        idle();
        total++; if ({fwd_valid, fwd_data} !== {1'b1, 32'd33}) begin bad++; $display("FAIL fwd_skip_nowrite: got v=%0h data=%0d want v=1 data=33", fwd_valid, fwd_data); end
        rf_ready = 1'b1;
        advance();
        advance();
        set_op(32'd55, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        idle();
        total++; if ({fwd_valid, rf_we} !== 2'b00) begin bad++; $display("FAIL fwd_r0: got v=%0h we=%0h want 0 0", fwd_valid, rf_we); end
        advance();
    endtask

    task automatic test_overflow();
        rf_ready = 1'b1;
        set_op(32'd7, 3'b000, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        idle();
        status_clr = 1'b1;
        total++; if ({rf_we, trap_req} !== {!TRAP_EN, TRAP_EN}) begin bad++; $display("FAIL ovf_head: got we=%0h trap=%0h want we=%0h trap=%0h", rf_we, trap_req, !TRAP_EN, TRAP_EN); end
        advance();
        status_clr = 1'b0;
        total++; if (st_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %0h want 1", st_overflow); end
        status_clr = 1'b1;
        advance();
        status_clr = 1'b0;
        total++; if (st_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0h want 0", st_overflow); end
        if (TRAP_EN) begin
            set_op(32'd70, 3'b000, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
            advance();
            set_op(32'd80, 3'b000, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            total++; if ({trap_req, in_ready, rf_we} !== 3'b110) begin bad++; $display("FAIL trap_pulse: got trap/ready/we=%0b want 110", {trap_req, in_ready, rf_we}); end
            advance();
            idle();
            total++; if ({trap_req, rf_we, fwd_valid, in_ready, st_overflow} !== 5'b00011) begin bad++; $display("FAIL trap_flush: got trap/we/fwd/ready/ovf=%0b want 00011", {trap_req, rf_we, fwd_valid, in_ready, st_overflow}); end
            status_clr = 1'b1;
            advance();
            status_clr = 1'b0;
        end
    endtask

    task automatic test_reset_full();
        rf_ready = 1'b0;
        set_op(32'd1, 3'b001, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        advance();
        set_op(32'd2, 3'b000, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        idle();
        total++; if ({in_ready, rf_we} !== 2'b01) begin bad++; $display("FAIL rstfull_pre: got ready/we=%0b want 01", {in_ready, rf_we}); end
        reset = 1'b1;
        advance();
        total++; if ({rf_we, fwd_valid, in_ready, rf_waddr} !== 8'h0) begin bad++; $display("FAIL rstfull_after: got we/fwd/ready/addr=%0h want 0", {rf_we, fwd_valid, in_ready, rf_waddr}); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_release: got %0h want 1", in_ready); end
    endtask

    task automatic test_random();
        logic [81:0] exp_v, got_v;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            rf_ready   = ($urandom_range(0, 9) < 7);
            status_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 7)
                set_op($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8),
                       5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
                       1'($urandom), 1'($urandom), 1'($urandom));
            else
                idle();
            #1;
            exp_v = model_outputs();
            got_v = {in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
                     st_zero, st_equals, st_above, st_overflow, trap_req};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, got_v, exp_v);
            end
            advance();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_compare();
        test_backpressure();
        test_forwarding();
        test_overflow();
        test_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
